// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank arbiter slice.
//   state_e   : controller state encoding (IDLE=1'b0, APPLY=1'b1)
//   DEF_NREQ  : default number of requesters
//   DEF_WIDTH : default number of JK bits in the bank
package jk_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage : jk_bank_pkg

// File: rtl/jk_bank_cell.sv
// One JK storage bit of the shared bank.
// Ports:
//   clk     : rising-edge clock
//   RESET_N : asynchronous active-low reset, clears q
//   clr     : synchronous clear, wins over en
//   en      : apply j/k on this edge
//   j, k    : JK controls (11 toggle, 10 set, 01 clear, 00 hold)
//   q       : stored bit
module jk_bank_cell (
  input  logic clk,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule : jk_bank_cell

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter and controller for a shared bank of JK bits.
// A granted requester's J/K masks are latched at the grant edge and applied
// to the bank on the following edge; done pulses once the bank is updated.
// Ports:
//   clk, RESET_N : clock, asynchronous active-low reset
//   req          : per-requester request, held until the matching gnt is seen
//   j_in, k_in   : packed masks, requester r owns [r*WIDTH +: WIDTH]
//   clr_all      : synchronous clear of the bank and controller (ptr kept)
//   gnt          : one-hot grant, high for the APPLY cycle
//   busy         : high while in APPLY
//   done         : one-cycle pulse after the bank update
//   done_id      : requester that completed, valid with done
//   q            : bank contents
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] j_in,
  input  logic [NREQ*WIDTH-1:0] k_in,
  input  logic                  clr_all,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      q
);

  state_e           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] j_lat;
  logic [WIDTH-1:0] k_lat;

  // Round-robin search result for the current cycle.
  logic [NREQ-1:0]  req_rot;
  logic [IDW-1:0]   pick;
  logic [WIDTH-1:0] pick_j;
  logic [WIDTH-1:0] pick_k;

  // Rotate req so bit 0 is the requester at ptr; the lowest set bit of the
  // rotated vector is then the round-robin winner, offset from ptr.
  assign req_rot = NREQ'({req, req} >> ptr);

  // NOTE: every output of this block gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int sum;
    pick   = '0;
    pick_j = '0;
    pick_k = '0;
    sum    = 0;
    // Descending scan: the last hit is the smallest offset from ptr.
    for (int o = NREQ - 1; o >= 0; o--) begin
      if (req_rot[o]) begin
        sum = int'(ptr) + o;
        if (sum >= NREQ) sum = sum - NREQ;
        pick = IDW'(sum);
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (IDW'(r) == pick) begin
        pick_j = j_in[r*WIDTH +: WIDTH];
        pick_k = k_in[r*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      ptr     <= '0;
      win_id  <= '0;
      j_lat   <= '0;
      k_lat   <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
    end else if (clr_all) begin
      // Drops any in-flight command; ptr keeps its position.
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (|req) begin
            state  <= APPLY;
            win_id <= pick;
            j_lat  <= pick_j;
            k_lat  <= pick_k;
            gnt    <= NREQ'(1) << pick;
            busy   <= 1'b1;
          end
        end
        APPLY: begin
          // The bank cells update on this same edge (enable = busy).
          state   <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          done_id <= win_id;
          ptr     <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    jk_bank_cell u_cell (
      .clk     (clk),
      .RESET_N (RESET_N),
      .clr     (clr_all),
      .en      (busy),
      .j       (j_lat[b]),
      .k       (k_lat[b]),
      .q       (q[b])
    );
  end

endmodule : jk_bank_arbiter
